decipher: RTL

DECIPHER -- requirements
Module: decipher

---
 rtl/decipher_pkg.sv | 53 +++++
 rtl/decipher_inv_round.sv | 44 ++++
 rtl/decipher.sv | 95 +++++++++
 3 files changed

// File: rtl/decipher_pkg.sv
// decipher_pkg: shared AES-128 constants, FSM state type and GF(2^8) helpers
// used by the inverse-cipher datapath.
//   BLK_S / KEY_S : block and key widths in bits
//   NR            : number of rounds (round keys NR..0)
//   inv_sbox()    : FIPS-197 inverse S-box
//   gf_mul()      : GF(2^8) multiply, reduction polynomial 0x11b
// This package replaces the former aes.vh include.
package decipher_pkg;

    localparam int unsigned BLK_S = 128;
    localparam int unsigned KEY_S = 128;
    localparam logic [3:0]  NR    = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ROUNDS,
        DONE
    } dec_state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_xtime(aa);
        end
        return p;
    endfunction

    // Inverse S-box = multiplicative inverse of the inverse affine transform.
    // The inverse is formed as x^254 (0 maps to 0 naturally).
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] t, t2, t3, t12, t15, t240;
        t    = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        t2   = gf_mul(t, t);
        t3   = gf_mul(t2, t);
        t12  = gf_mul(gf_mul(t3, t3), gf_mul(t3, t3));
        t15  = gf_mul(t12, t3);
        t240 = gf_mul(t15, t15);
        t240 = gf_mul(t240, t240);
        t240 = gf_mul(t240, t240);
        t240 = gf_mul(t240, t240);
        return gf_mul(gf_mul(t240, t12), t2);
    endfunction

endpackage

// File: rtl/decipher_inv_round.sv
// inv_round: one combinational AES inverse-cipher round.
//   state_in   : current state, byte 0 at bits [0:7], column-major
//   round_key  : round key to add
//   last_round : 1 = skip InvMixColumns (final round)
//   state_out  : InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_in))))
module inv_round
    import decipher_pkg::*;
(
    input  logic [0:BLK_S-1] state_in,
    input  logic [0:KEY_S-1] round_key,
    input  logic             last_round,
    output logic [0:BLK_S-1] state_out
);

    logic [7:0] ark [16];

    always_comb begin
        state_out = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                // InvShiftRows: row r rotates right by r, so out[r][c] = in[r][c-r].
                ark[r + 4*c] = inv_sbox(state_in[8*(r + 4*((c + 4 - r) % 4)) +: 8])
                               ^ round_key[8*(r + 4*c) +: 8];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            if (last_round) begin
                for (int unsigned r = 0; r < 4; r++) begin
                    state_out[8*(r + 4*c) +: 8] = ark[r + 4*c];
                end
            end else begin
                state_out[8*(4*c) +: 8]     = gf_mul(ark[4*c], 8'h0e) ^ gf_mul(ark[4*c+1], 8'h0b)
                                            ^ gf_mul(ark[4*c+2], 8'h0d) ^ gf_mul(ark[4*c+3], 8'h09);
                state_out[8*(4*c + 1) +: 8] = gf_mul(ark[4*c], 8'h09) ^ gf_mul(ark[4*c+1], 8'h0e)
                                            ^ gf_mul(ark[4*c+2], 8'h0b) ^ gf_mul(ark[4*c+3], 8'h0d);
                state_out[8*(4*c + 2) +: 8] = gf_mul(ark[4*c], 8'h0d) ^ gf_mul(ark[4*c+1], 8'h09)
                                            ^ gf_mul(ark[4*c+2], 8'h0e) ^ gf_mul(ark[4*c+3], 8'h0b);
                state_out[8*(4*c + 3) +: 8] = gf_mul(ark[4*c], 8'h0b) ^ gf_mul(ark[4*c+1], 8'h0d)
                                            ^ gf_mul(ark[4*c+2], 8'h09) ^ gf_mul(ark[4*c+3], 8'h0e);
            end
        end
    end

endmodule

// File: rtl/decipher.sv
// decipher: iterative AES-128 inverse cipher, one round per clock.
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   en           : start strobe, honoured only in IDLE
//   ciphertext   : input block, byte 0 at bits [0:7]
//   key          : round key from external SRAM, valid one cycle after round_key_no
//   round_key_no : registered round-key index (NR down to 0)
//   plaintext    : registered result, held until the next completion
//   en_o         : one-cycle done pulse
module decipher
    import decipher_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [0:BLK_S-1] ciphertext,
    input  logic [0:KEY_S-1] key,
    output logic [0:3]       round_key_no,
    output logic [0:BLK_S-1] plaintext,
    output logic             en_o
);

    dec_state_t       state_q, state_d;
    logic [0:BLK_S-1] blk_q;
    logic [0:BLK_S-1] round_out;
    logic [3:0]       rnd_q;       // index of the round key the datapath consumes next
    logic             prime_last;
    logic             last_round;

    // PRIME spans two edges: the first only advances the key index (SRAM
    // latency bubble), the second applies rk NR once it has arrived.
    assign prime_last = (round_key_no == NR - 4'd1);
    assign last_round = (rnd_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        en_o    = 1'b0;
        case (state_q)
            IDLE:    if (en) state_d = PRIME;
            PRIME:   if (prime_last) state_d = ROUNDS;
            ROUNDS:  if (last_round) state_d = DONE;
            DONE: begin
                en_o    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_q        <= '0;
            rnd_q        <= '0;
            round_key_no <= '0;
            plaintext    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        blk_q        <= ciphertext;
                        round_key_no <= NR;
                        rnd_q        <= NR;
                    end
                end
                PRIME: begin
                    round_key_no <= round_key_no - 4'd1;
                    if (prime_last) begin
                        blk_q <= blk_q ^ key;
                        rnd_q <= NR - 4'd1;
                    end
                end
                ROUNDS: begin
                    blk_q <= round_out;
                    if (round_key_no != '0) round_key_no <= round_key_no - 4'd1;
                    if (last_round) plaintext <= round_out;
                    else            rnd_q     <= rnd_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    inv_round u_inv_round (
        .state_in   (blk_q),
        .round_key  (key),
        .last_round (last_round),
        .state_out  (round_out)
    );

endmodule
